// File: rtl/operand_forward_buffer_pkg.sv
// Shared constants and state encoding for the operand forwarding stage.
// Tag 0 is the "no dependency" marker throughout.
package operand_forward_buffer_pkg;

    localparam int DEF_ROB_ID_W = 5;
    localparam int DEF_DATA_W   = 32;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    localparam logic [DEF_ROB_ID_W-1:0] ZERO_ROB = '0;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_HELD  = 1'b1
    } state_e;

endpackage

// File: rtl/fwd_operand_resolve.sv
// Combinational (Q,V) resolution of one operand: ready tag, then lowest CDB hit, then ROB.
// Zero latency; no handshake.
module fwd_operand_resolve
    import operand_forward_buffer_pkg::*;
#(
    parameter int NUM_CDB  = 2,
    parameter int ROB_ID_W = DEF_ROB_ID_W,
    parameter int DATA_W   = DEF_DATA_W
) (
    input  logic [ROB_ID_W-1:0]         tag_i,
    input  logic [DATA_W-1:0]           val_i,
    input  logic                        rob_rdy_i,
    input  logic [DATA_W-1:0]           rob_val_i,
    input  logic [NUM_CDB-1:0]          cdb_valid_i,
    input  logic [NUM_CDB*ROB_ID_W-1:0] cdb_rob_id_i,
    input  logic [NUM_CDB*DATA_W-1:0]   cdb_result_i,
    output logic [ROB_ID_W-1:0]         q_o,
    output logic [DATA_W-1:0]           v_o
);

    localparam logic [ROB_ID_W-1:0] ZERO_TAG = ROB_ID_W'(ZERO_ROB);

    logic              hit;
    logic [DATA_W-1:0] hit_val;

    // Scan high to low so the lowest-index matching channel is the last writer.
    always_comb begin
        hit     = FALSE;
        hit_val = '0;
        for (int c = NUM_CDB - 1; c >= 0; c--) begin
            if (cdb_valid_i[c] && (cdb_rob_id_i[c*ROB_ID_W +: ROB_ID_W] == tag_i)) begin
                hit     = TRUE;
                hit_val = cdb_result_i[c*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        q_o = tag_i;
        v_o = val_i;
        if (tag_i == ZERO_TAG) begin
            q_o = ZERO_TAG;
            v_o = val_i;
        end else if (hit) begin
            q_o = ZERO_TAG;
            v_o = hit_val;
        end else if (rob_rdy_i) begin
            q_o = ZERO_TAG;
            v_o = rob_val_i;
        end
    end

endmodule

// File: rtl/operand_forward_buffer.sv
// One-entry operand resolve/hold buffer between issue and dispatch; capture-to-out_valid 1 cycle.
// Backpressure: in_ready only when empty or draining; held entry snoops CDB while stalled.
// Optional OPERAND_FWD_SAME_CYCLE_EN passes held operands through the snoop mux combinationally.
module operand_forward_buffer
    import operand_forward_buffer_pkg::*;
#(
    parameter int NUM_SRC   = 2,
    parameter int NUM_CDB   = 2,
    parameter int ROB_ID_W  = DEF_ROB_ID_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int PAYLOAD_W = 64
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        rdy,
    input  logic                        flush,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [PAYLOAD_W-1:0]        in_payload,
    input  logic [NUM_SRC*ROB_ID_W-1:0] reg_Q,
    input  logic [NUM_SRC*DATA_W-1:0]   reg_V,
    input  logic [NUM_SRC-1:0]          rob_Q_ready,
    input  logic [NUM_SRC*DATA_W-1:0]   rob_V,
    input  logic [NUM_CDB-1:0]          cdb_valid,
    input  logic [NUM_CDB*ROB_ID_W-1:0] cdb_rob_id,
    input  logic [NUM_CDB*DATA_W-1:0]   cdb_result,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [NUM_SRC*ROB_ID_W-1:0] out_Q,
    output logic [NUM_SRC*DATA_W-1:0]   out_V,
    output logic                        out_all_ready,
    output logic [PAYLOAD_W-1:0]        out_payload
);

    state_e                      state_q, state_d;
    logic [NUM_SRC*ROB_ID_W-1:0] q_q, q_d;
    logic [NUM_SRC*DATA_W-1:0]   v_q, v_d;
    logic [PAYLOAD_W-1:0]        pay_q, pay_d;

    logic [NUM_SRC*ROB_ID_W-1:0] cap_q, snp_q;
    logic [NUM_SRC*DATA_W-1:0]   cap_v, snp_v;

    logic held, hs, cap;

    assign held      = (state_q == ST_HELD);
    assign out_valid = held;
    assign hs        = held && out_ready;
    assign in_ready  = rdy && (!held || hs);
    assign cap       = in_valid && in_ready && !flush;

    for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
        fwd_operand_resolve #(
            .NUM_CDB (NUM_CDB),
            .ROB_ID_W(ROB_ID_W),
            .DATA_W  (DATA_W)
        ) u_cap (
            .tag_i       (reg_Q[s*ROB_ID_W +: ROB_ID_W]),
            .val_i       (reg_V[s*DATA_W +: DATA_W]),
            .rob_rdy_i   (rob_Q_ready[s]),
            .rob_val_i   (rob_V[s*DATA_W +: DATA_W]),
            .cdb_valid_i (cdb_valid),
            .cdb_rob_id_i(cdb_rob_id),
            .cdb_result_i(cdb_result),
            .q_o         (cap_q[s*ROB_ID_W +: ROB_ID_W]),
            .v_o         (cap_v[s*DATA_W +: DATA_W])
        );

        // The ROB already reported at capture time, so snoop only listens to the CDB.
        fwd_operand_resolve #(
            .NUM_CDB (NUM_CDB),
            .ROB_ID_W(ROB_ID_W),
            .DATA_W  (DATA_W)
        ) u_snp (
            .tag_i       (q_q[s*ROB_ID_W +: ROB_ID_W]),
            .val_i       (v_q[s*DATA_W +: DATA_W]),
            .rob_rdy_i   (FALSE),
            .rob_val_i   ({DATA_W{1'b0}}),
            .cdb_valid_i (cdb_valid),
            .cdb_rob_id_i(cdb_rob_id),
            .cdb_result_i(cdb_result),
            .q_o         (snp_q[s*ROB_ID_W +: ROB_ID_W]),
            .v_o         (snp_v[s*DATA_W +: DATA_W])
        );
    end

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        v_d     = v_q;
        pay_d   = pay_q;
        if (rdy) begin
            if (flush) begin
                state_d = ST_EMPTY;
            end else if (cap) begin
                state_d = ST_HELD;
                q_d     = cap_q;
                v_d     = cap_v;
                pay_d   = in_payload;
            end else if (hs) begin
                state_d = ST_EMPTY;
            end else if (held) begin
                q_d = snp_q;
                v_d = snp_v;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            q_q     <= '0;
            v_q     <= '0;
            pay_q   <= '0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            v_q     <= v_d;
            pay_q   <= pay_d;
        end
    end

`ifdef OPERAND_FWD_SAME_CYCLE_EN
    assign out_Q = snp_q;
    assign out_V = snp_v;
`else
    assign out_Q = q_q;
    assign out_V = v_q;
`endif
    assign out_payload = pay_q;

    always_comb begin
        out_all_ready = TRUE;
        for (int s = 0; s < NUM_SRC; s++) begin
            if (out_Q[s*ROB_ID_W +: ROB_ID_W] != '0) out_all_ready = FALSE;
        end
    end

endmodule

// File: tb/tb_operand_forward_buffer.sv
// Directed bench for operand_forward_buffer (default build) with a scoreboard of held entries.
module tb_operand_forward_buffer;

    localparam int NS = 2;
    localparam int NC = 2;
    localparam int RW = 5;
    localparam int DW = 32;
    localparam int PW = 64;

    typedef struct packed {
        logic [NS*RW-1:0] q;
        logic [NS*DW-1:0] v;
        logic [PW-1:0]    p;
    } ent_t;

    logic             clk = 1'b0;
    logic             rst, rdy, flush, in_valid, out_ready;
    logic             in_ready, out_valid, out_all_ready;
    logic [PW-1:0]    in_payload, out_payload;
    logic [NS*RW-1:0] reg_Q, out_Q;
    logic [NS*DW-1:0] reg_V, rob_V, out_V;
    logic [NS-1:0]    rob_Q_ready;
    logic [NC-1:0]    cdb_valid;
    logic [NC*RW-1:0] cdb_rob_id;
    logic [NC*DW-1:0] cdb_result;

    int   checks = 0;
    int   failures = 0;
    int   delivered = 0;
    ent_t sb[$];
    ent_t snap;

    always #5 clk = ~clk;

    operand_forward_buffer #(
        .NUM_SRC(NS), .NUM_CDB(NC), .ROB_ID_W(RW), .DATA_W(DW), .PAYLOAD_W(PW)
    ) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_payload(in_payload),
        .reg_Q(reg_Q), .reg_V(reg_V), .rob_Q_ready(rob_Q_ready), .rob_V(rob_V),
        .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id), .cdb_result(cdb_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_Q(out_Q), .out_V(out_V),
        .out_all_ready(out_all_ready), .out_payload(out_payload)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void resolve(input logic [RW-1:0] tag, input logic [DW-1:0] val,
                                    input logic use_rob, input logic rr, input logic [DW-1:0] rv,
                                    output logic [RW-1:0] qo, output logic [DW-1:0] vo);
        qo = tag;
        vo = val;
        if (tag == '0) return;
        for (int c = 0; c < NC; c++) begin
            if (cdb_valid[c] && cdb_rob_id[c*RW +: RW] == tag) begin
                qo = '0;
                vo = cdb_result[c*DW +: DW];
                return;
            end
        end
        if (use_rob && rr) begin
            qo = '0;
            vo = rv;
        end
    endfunction

    function automatic ent_t model_cap();
        ent_t e;
        logic [RW-1:0] q;
        logic [DW-1:0] v;
        for (int s = 0; s < NS; s++) begin
            resolve(reg_Q[s*RW +: RW], reg_V[s*DW +: DW], 1'b1, rob_Q_ready[s], rob_V[s*DW +: DW], q, v);
            e.q[s*RW +: RW] = q;
            e.v[s*DW +: DW] = v;
        end
        e.p = in_payload;
        return e;
    endfunction

    function automatic ent_t model_snoop(input ent_t e);
        ent_t r = e;
        logic [RW-1:0] q;
        logic [DW-1:0] v;
        for (int s = 0; s < NS; s++) begin
            resolve(e.q[s*RW +: RW], e.v[s*DW +: DW], 1'b0, 1'b0, '0, q, v);
            r.q[s*RW +: RW] = q;
            r.v[s*DW +: DW] = v;
        end
        return r;
    endfunction

    // Inputs are set after a falling edge; the model evaluates them before the next rising edge.
    task automatic tick();
        ent_t e;
        logic hs, cap;
        #1;
        chk("in_ready", 128'(in_ready), 128'(rdy && (sb.size() == 0 || out_ready)));
        chk("out_valid", 128'(out_valid), 128'(sb.size() != 0));
        if (rdy) begin
            if (flush) begin
                if (sb.size() != 0) void'(sb.pop_front());
            end else begin
                hs  = (sb.size() != 0) && out_ready;
                cap = in_valid && (sb.size() == 0 || hs);
                if (hs) begin
                    e = sb.pop_front();
                    chk("deliver_Q", 128'(out_Q), 128'(e.q));
                    chk("deliver_V", 128'(out_V), 128'(e.v));
                    chk("deliver_payload", 128'(out_payload), 128'(e.p));
                    delivered++;
                end
                if (cap) sb.push_back(model_cap());
                else if (!hs && sb.size() != 0) sb[0] = model_snoop(sb[0]);
            end
        end
        @(negedge clk);
    endtask

    task automatic idle();
        in_valid    = 1'b0;
        flush       = 1'b0;
        cdb_valid   = '0;
        rob_Q_ready = '0;
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_payload = '0; reg_Q = '0; reg_V = '0; rob_Q_ready = '0; rob_V = '0;
        cdb_valid = '0; cdb_rob_id = '0; cdb_result = '0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_out_Q", 128'(out_Q), 128'(0));
        chk("rst_out_V", 128'(out_V), 128'(0));
        chk("rst_out_payload", 128'(out_payload), 128'(0));
        rst = 1'b0;
        #1 chk("in_ready_rdy_low", 128'(in_ready), 128'(0));
        rdy = 1'b1;
        #1 chk("in_ready_after_reset", 128'(in_ready), 128'(1));
        @(negedge clk);

        // ch1 forwards tag 3
        reg_Q = {5'd0, 5'd3}; reg_V = {32'h1111_0000, 32'h2222_0000};
        cdb_valid = 2'b10; cdb_rob_id = {5'd3, 5'd0}; cdb_result = {32'hAB, 32'hCD};
        in_valid = 1'b1; in_payload = 64'hA5A5_0000_0000_0001;
        tick(); idle();
        chk("cap_ch1_Q0", 128'(out_Q[0 +: RW]), 128'(0));
        chk("cap_ch1_V0", 128'(out_V[0 +: DW]), 128'(32'hAB));
        out_ready = 1'b1; tick(); out_ready = 1'b0;

        // both channels carry tag 3: ch0 wins
        cdb_valid = 2'b11; cdb_rob_id = {5'd3, 5'd3}; cdb_result = {32'hAB, 32'h11};
        in_valid = 1'b1; in_payload = 64'h2;
        tick(); idle();
        chk("cap_ch0_wins_V0", 128'(out_V[0 +: DW]), 128'(32'h11));
        out_ready = 1'b1; tick(); out_ready = 1'b0;

        // src0 via ROB, src1 (tag 7) left pending
        reg_Q = {5'd7, 5'd5}; reg_V = {32'h7777, 32'h5555};
        rob_Q_ready = 2'b01; rob_V = {32'hDEAD, 32'h77};
        in_valid = 1'b1; in_payload = 64'h3;
        tick(); idle();
        chk("rob_V0", 128'(out_V[0 +: DW]), 128'(32'h77));
        chk("pending_Q1", 128'(out_Q[RW +: RW]), 128'(7));
        chk("not_all_ready", 128'(out_all_ready), 128'(0));
        // snoop wakeup; ch1 tag 5 must not disturb the already-ready src0
        cdb_valid = 2'b11; cdb_rob_id = {5'd5, 5'd7}; cdb_result = {32'hEE, 32'h55};
        tick(); idle();
        chk("snoop_Q1", 128'(out_Q[RW +: RW]), 128'(0));
        chk("snoop_V1", 128'(out_V[DW +: DW]), 128'(32'h55));
        chk("snoop_keep_V0", 128'(out_V[0 +: DW]), 128'(32'h77));
        chk("snoop_all_ready", 128'(out_all_ready), 128'(1));
        out_ready = 1'b1; tick(); out_ready = 1'b0;

        // back-to-back transfer
        delivered = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            reg_Q = {5'(i + 1), 5'(i + 9)}; reg_V = {32'($urandom), 32'($urandom)};
            in_payload = {32'hB2B0_0000, 32'(i)};
            in_valid = 1'b1;
            tick();
        end
        idle();
        for (int i = 0; i < 8 && sb.size() != 0; i++) tick();
        chk("b2b_delivered", 128'(delivered), 128'(4));
        out_ready = 1'b0;

        // flush while held drops the concurrent capture
        reg_Q = {5'd4, 5'd0}; reg_V = {32'h44, 32'h40}; in_valid = 1'b1; in_payload = 64'hF1;
        tick();
        snap = sb[0];
        flush = 1'b1; in_valid = 1'b1; in_payload = 64'hF2; reg_Q = '0;
        tick(); idle();
        chk("flush_out_valid", 128'(out_valid), 128'(0));
        chk("flush_keep_Q", 128'(out_Q), 128'(snap.q));
        chk("flush_keep_payload", 128'(out_payload), 128'(snap.p));
        tick();

        // rdy low freezes everything during a matching broadcast
        reg_Q = {5'd6, 5'd0}; reg_V = {32'h66, 32'h60}; in_valid = 1'b1; in_payload = 64'hC6;
        tick(); idle();
        rdy = 1'b0; out_ready = 1'b1; in_valid = 1'b1;
        cdb_valid = 2'b10; cdb_rob_id = {5'd6, 5'd0}; cdb_result = {32'h99, 32'h0};
        repeat (3) tick();
        chk("frozen_Q1", 128'(out_Q[RW +: RW]), 128'(6));
        chk("frozen_V1", 128'(out_V[DW +: DW]), 128'(32'h66));
        idle(); rdy = 1'b1;
        tick(); out_ready = 1'b0;

        // asynchronous reset mid-hold
        reg_Q = {5'd9, 5'd9}; in_valid = 1'b1; in_payload = 64'h99;
        tick(); idle();
        rst = 1'b1;
        #1;
        chk("arst_out_valid", 128'(out_valid), 128'(0));
        chk("arst_out_Q", 128'(out_Q), 128'(0));
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        #1 chk("arst_in_ready", 128'(in_ready), 128'(1));
        @(negedge clk);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
